controlador_trayectoria: RTL and testbench

CONTROLADOR_TRAYECTORIA -- requirements
Module: controlador_trayectoria

---
 rtl/controlador_trayectoria.sv | 139 +++++++++++++
 tb/tb_controlador_trayectoria.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/controlador_trayectoria.sv
// Records a path of points into an internal memory and plays it back one point per step command.
// Define REPETIR_CICLO_EN to loop playback forever; otherwise playback stops in FIN at the last point.
module controlador_trayectoria #(
    parameter int unsigned BITS_EJE         = 6,
    parameter int unsigned NUM_EJES         = 2,
    parameter int unsigned DIRECCIONAMIENTO = 9
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             grabar,
    input  logic                             iniciar_detener,
    input  logic                             pausar_reanudar,
    input  logic                             cancelar,
    input  logic                             guardar_xy,
    input  logic                             dato_siguiente,
    input  logic [NUM_EJES*BITS_EJE-1:0]     coord_sensor,
    output logic [NUM_EJES*BITS_EJE-1:0]     coord_salida,
    output logic                             cortando,
    output logic                             lleno,
    output logic                             corte_terminado,
    output logic [DIRECCIONAMIENTO:0]        num_puntos,
    output logic [2:0]                       estado_actual
);

    localparam int unsigned ANCHO_PUNTO = NUM_EJES * BITS_EJE;
    localparam int unsigned ANCHO_CNT   = DIRECCIONAMIENTO + 1;
    localparam int unsigned PROFUNDIDAD = 1 << DIRECCIONAMIENTO;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        GRABAR = 3'd1,
        LISTO  = 3'd2,
        CORTAR = 3'd3,
        PAUSA  = 3'd4,
        FIN    = 3'd5
    } estado_t;

    estado_t                       estado;
    estado_t                       estado_sig;
    logic [DIRECCIONAMIENTO-1:0]   puntero;
    logic [DIRECCIONAMIENTO-1:0]   puntero_sig;
    logic [ANCHO_CNT-1:0]          cuenta_sig;
    logic                          escribir_c;
    logic                          fin_sig;
    logic                          ultimo_c;
    logic [ANCHO_PUNTO-1:0]        memoria [PROFUNDIDAD];

    assign lleno         = (num_puntos == ANCHO_CNT'(PROFUNDIDAD));
    assign ultimo_c      = (ANCHO_CNT'(puntero) == (num_puntos - ANCHO_CNT'(1)));
    assign estado_actual = estado;

    // Next-state logic; only the highest-priority pulse present is considered each cycle.
    always_comb begin
        estado_sig  = estado;
        puntero_sig = puntero;
        cuenta_sig  = num_puntos;
        escribir_c  = 1'b0;
        fin_sig     = 1'b0;

        if (cancelar) begin
            estado_sig  = IDLE;
            puntero_sig = '0;
            cuenta_sig  = '0;
        end else if (grabar) begin
            case (estado)
                IDLE, LISTO, FIN: begin
                    estado_sig = GRABAR;
                    cuenta_sig = '0;
                end
                GRABAR:  estado_sig = (num_puntos != '0) ? LISTO : IDLE;
                default: ;
            endcase
        end else if (iniciar_detener) begin
            case (estado)
                LISTO, FIN: begin
                    estado_sig  = CORTAR;
                    puntero_sig = '0;
                end
                CORTAR, PAUSA: begin
                    estado_sig  = LISTO;
                    puntero_sig = '0;
                end
                default: ;
            endcase
        end else if (pausar_reanudar) begin
            case (estado)
                CORTAR:  estado_sig = PAUSA;
                PAUSA:   estado_sig = CORTAR;
                default: ;
            endcase
        end else begin
            if (estado == GRABAR && guardar_xy && !lleno) begin
                escribir_c = 1'b1;
                cuenta_sig = num_puntos + ANCHO_CNT'(1);
            end
            if (estado == CORTAR && dato_siguiente) begin
                if (!ultimo_c) begin
                    puntero_sig = puntero + DIRECCIONAMIENTO'(1);
                end else begin
                    fin_sig = 1'b1;
`ifdef REPETIR_CICLO_EN
                    puntero_sig = '0;
`else
                    estado_sig = FIN;
`endif
                end
            end
        end
    end

    // State and datapath registers; coord_salida trails the pointer by one cycle.
    always_ff @(posedge clock) begin
        if (!reset) begin
            estado          <= IDLE;
            puntero         <= '0;
            num_puntos      <= '0;
            cortando        <= 1'b0;
            corte_terminado <= 1'b0;
            coord_salida    <= '0;
        end else begin
            estado          <= estado_sig;
            puntero         <= puntero_sig;
            num_puntos      <= cuenta_sig;
            cortando        <= (estado_sig == CORTAR);
            corte_terminado <= fin_sig;
            if (estado == CORTAR) begin
                coord_salida <= memoria[puntero];
            end
        end
    end

    // Point memory is not cleared by reset; the count alone defines valid contents.
    always_ff @(posedge clock) begin
        if (reset && escribir_c) begin
            memoria[num_puntos[DIRECCIONAMIENTO-1:0]] <= coord_sensor;
        end
    end

endmodule

// File: tb/tb_controlador_trayectoria.sv
// Self-checking bench: directed scenarios plus randomized commands against a queue-based model.
module tb_controlador_trayectoria;

    localparam int S_IDLE = 0, S_GRABAR = 1, S_LISTO = 2, S_CORTAR = 3, S_PAUSA = 4, S_FIN = 5;
    localparam logic [5:0] K_NONE = 6'b000000, K_CAN = 6'b100000, K_GRAB = 6'b010000,
                           K_INI  = 6'b001000, K_PAU = 6'b000100, K_SIG  = 6'b000010,
                           K_GUA  = 6'b000001;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset;
    logic        grabar, iniciar_detener, pausar_reanudar, cancelar, guardar_xy, dato_siguiente;
    logic [11:0] coord_sensor, coord_salida;
    logic        cortando, lleno, corte_terminado;
    logic [9:0]  num_puntos;
    logic [2:0]  estado_actual;

    logic        s_grabar, s_iniciar, s_pausar, s_cancelar, s_guardar, s_siguiente;
    logic [11:0] s_sensor, s_coord;
    logic        s_cortando, s_lleno, s_corte;
    logic [2:0]  s_num;
    logic [2:0]  s_estado;

    controlador_trayectoria u_dut (
        .clock(clock), .reset(reset),
        .grabar(grabar), .iniciar_detener(iniciar_detener), .pausar_reanudar(pausar_reanudar),
        .cancelar(cancelar), .guardar_xy(guardar_xy), .dato_siguiente(dato_siguiente),
        .coord_sensor(coord_sensor), .coord_salida(coord_salida),
        .cortando(cortando), .lleno(lleno), .corte_terminado(corte_terminado),
        .num_puntos(num_puntos), .estado_actual(estado_actual)
    );

    controlador_trayectoria #(.BITS_EJE(6), .NUM_EJES(2), .DIRECCIONAMIENTO(2)) u_small (
        .clock(clock), .reset(reset),
        .grabar(s_grabar), .iniciar_detener(s_iniciar), .pausar_reanudar(s_pausar),
        .cancelar(s_cancelar), .guardar_xy(s_guardar), .dato_siguiente(s_siguiente),
        .coord_sensor(s_sensor), .coord_salida(s_coord),
        .cortando(s_cortando), .lleno(s_lleno), .corte_terminado(s_corte),
        .num_puntos(s_num), .estado_actual(s_estado)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model: a list of recorded points, a cursor and the displayed point.
    int          m_state;
    logic [11:0] pts[$];
    int          m_ptr;
    logic [11:0] m_coord;
    logic        m_fin;

    function automatic void model_reset();
        m_state = S_IDLE;
        pts.delete();
        m_ptr   = 0;
        m_coord = 12'h000;
        m_fin   = 1'b0;
    endfunction

    function automatic void model_step(input logic [5:0] k, input logic [11:0] sensor);
        int prev = m_state;
        if (prev == S_CORTAR) m_coord = pts[m_ptr];
        m_fin = 1'b0;
        if (k[5]) begin
            m_state = S_IDLE;
            pts.delete();
            m_ptr = 0;
        end else if (k[4]) begin
            if (prev inside {S_IDLE, S_LISTO, S_FIN}) begin
                m_state = S_GRABAR;
                pts.delete();
            end else if (prev == S_GRABAR) begin
                m_state = (pts.size() > 0) ? S_LISTO : S_IDLE;
            end
        end else if (k[3]) begin
            if (prev inside {S_LISTO, S_FIN}) begin
                m_state = S_CORTAR;
                m_ptr = 0;
            end else if (prev inside {S_CORTAR, S_PAUSA}) begin
                m_state = S_LISTO;
                m_ptr = 0;
            end
        end else if (k[2]) begin
            if (prev == S_CORTAR) m_state = S_PAUSA;
            else if (prev == S_PAUSA) m_state = S_CORTAR;
        end else begin
            if (prev == S_GRABAR && k[0] && pts.size() < 512) pts.push_back(sensor);
            if (prev == S_CORTAR && k[1]) begin
                if (m_ptr < pts.size() - 1) m_ptr++;
                else begin
                    m_fin = 1'b1;
`ifdef REPETIR_CICLO_EN
                    m_ptr = 0;
`else
                    m_state = S_FIN;
`endif
                end
            end
        end
    endfunction

    // Drives one cycle of commands on the main instance; returns at the following negedge.
    task automatic apply(input logic [5:0] k, input logic [11:0] sensor);
        {cancelar, grabar, iniciar_detener, pausar_reanudar, dato_siguiente, guardar_xy} = k;
        coord_sensor = sensor;
        @(posedge clock);
        model_step(k, sensor);
        @(negedge clock);
        {cancelar, grabar, iniciar_detener, pausar_reanudar, dato_siguiente, guardar_xy} = 6'b0;
    endtask

    task automatic apply_small(input logic [5:0] k, input logic [11:0] sensor);
        {s_cancelar, s_grabar, s_iniciar, s_pausar, s_siguiente, s_guardar} = k;
        s_sensor = sensor;
        @(posedge clock);
        model_step(K_NONE, 12'h000);
        @(negedge clock);
        {s_cancelar, s_grabar, s_iniciar, s_pausar, s_siguiente, s_guardar} = 6'b0;
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b0;
        repeat (cycles) begin
            @(posedge clock);
            model_reset();
        end
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset(2);
        n_checks++; if (estado_actual !== 3'd0) $display("FAIL reset_state: got %0d expected 0", estado_actual); else n_pass++;
        n_checks++; if (num_puntos !== 10'd0) $display("FAIL reset_num: got %0d expected 0", num_puntos); else n_pass++;
        n_checks++; if ({cortando, lleno, corte_terminado} !== 3'b000) $display("FAIL reset_flags: got %b expected 000", {cortando, lleno, corte_terminado}); else n_pass++;
        n_checks++; if (coord_salida !== 12'h000) $display("FAIL reset_coord: got %h expected 000", coord_salida); else n_pass++;
        n_checks++; if (s_num !== 3'd0 || s_lleno !== 1'b0) $display("FAIL reset_small: got num %0d lleno %b expected 0 0", s_num, s_lleno); else n_pass++;
    endtask

    task automatic test_path();
        apply(K_CAN, 12'h0); apply(K_GRAB, 12'h0);
        n_checks++; if (estado_actual !== 3'd1) $display("FAIL path_grabar: got %0d expected 1", estado_actual); else n_pass++;
        apply(K_GUA, 12'h041); apply(K_GUA, 12'h082); apply(K_GUA, 12'h0C3);
        n_checks++; if (num_puntos !== 10'd3 || lleno !== 1'b0) $display("FAIL path_count: got %0d/%b expected 3/0", num_puntos, lleno); else n_pass++;
        apply(K_GRAB, 12'h0);
        n_checks++; if (estado_actual !== 3'd2) $display("FAIL path_listo: got %0d expected 2", estado_actual); else n_pass++;
        apply(K_INI, 12'h0);
        n_checks++; if (estado_actual !== 3'd3 || cortando !== 1'b1) $display("FAIL path_cortar: got %0d/%b expected 3/1", estado_actual, cortando); else n_pass++;
        apply(K_NONE, 12'h0);
        n_checks++; if (coord_salida !== 12'h041) $display("FAIL path_p0: got %h expected 041", coord_salida); else n_pass++;
        apply(K_SIG, 12'h0); apply(K_NONE, 12'h0);
        n_checks++; if (coord_salida !== 12'h082 || corte_terminado !== 1'b0) $display("FAIL path_p1: got %h/%b expected 082/0", coord_salida, corte_terminado); else n_pass++;
        apply(K_SIG, 12'h0); apply(K_NONE, 12'h0);
        n_checks++; if (coord_salida !== 12'h0C3) $display("FAIL path_p2: got %h expected 0C3", coord_salida); else n_pass++;
        apply(K_SIG, 12'h0);
        n_checks++; if (corte_terminado !== 1'b1) $display("FAIL path_pulse: got %b expected 1", corte_terminado); else n_pass++;
`ifdef REPETIR_CICLO_EN
        n_checks++; if (estado_actual !== 3'd3 || cortando !== 1'b1) $display("FAIL path_loop_state: got %0d/%b expected 3/1", estado_actual, cortando); else n_pass++;
        apply(K_NONE, 12'h0);
        n_checks++; if (coord_salida !== 12'h041 || corte_terminado !== 1'b0) $display("FAIL path_wrap: got %h/%b expected 041/0", coord_salida, corte_terminado); else n_pass++;
`else
        n_checks++; if (estado_actual !== 3'd5 || cortando !== 1'b0) $display("FAIL path_fin_state: got %0d/%b expected 5/0", estado_actual, cortando); else n_pass++;
        apply(K_NONE, 12'h0);
        n_checks++; if (coord_salida !== 12'h0C3 || corte_terminado !== 1'b0) $display("FAIL path_hold: got %h/%b expected 0C3/0", coord_salida, corte_terminado); else n_pass++;
`endif
    endtask

    task automatic test_pause();
        apply(K_CAN, 12'h0); apply(K_GRAB, 12'h0);
        apply(K_GUA, 12'h111); apply(K_GUA, 12'h222); apply(K_GUA, 12'h333);
        apply(K_GRAB, 12'h0); apply(K_INI, 12'h0); apply(K_SIG, 12'h0); apply(K_NONE, 12'h0);
        n_checks++; if (coord_salida !== 12'h222) $display("FAIL pause_p1: got %h expected 222", coord_salida); else n_pass++;
        apply(K_PAU, 12'h0);
        n_checks++; if (estado_actual !== 3'd4 || cortando !== 1'b0) $display("FAIL pause_enter: got %0d/%b expected 4/0", estado_actual, cortando); else n_pass++;
        apply(K_SIG, 12'h0); apply(K_NONE, 12'h0);
        n_checks++; if (estado_actual !== 3'd4 || coord_salida !== 12'h222) $display("FAIL pause_hold: got %0d/%h expected 4/222", estado_actual, coord_salida); else n_pass++;
        apply(K_PAU, 12'h0);
        n_checks++; if (estado_actual !== 3'd3) $display("FAIL pause_resume: got %0d expected 3", estado_actual); else n_pass++;
        apply(K_NONE, 12'h0);
        n_checks++; if (coord_salida !== 12'h222) $display("FAIL pause_ptr_kept: got %h expected 222", coord_salida); else n_pass++;
    endtask

    task automatic test_cancel();
        apply(K_SIG, 12'h0); apply(K_NONE, 12'h0);
        n_checks++; if (coord_salida !== 12'h333) $display("FAIL cancel_last: got %h expected 333", coord_salida); else n_pass++;
        apply(K_CAN | K_SIG, 12'h0);
        n_checks++; if (estado_actual !== 3'd0 || num_puntos !== 10'd0) $display("FAIL cancel_state: got %0d/%0d expected 0/0", estado_actual, num_puntos); else n_pass++;
        n_checks++; if (corte_terminado !== 1'b0 || cortando !== 1'b0) $display("FAIL cancel_flags: got %b/%b expected 0/0", corte_terminado, cortando); else n_pass++;
        apply(K_NONE, 12'h0);
        n_checks++; if (corte_terminado !== 1'b0) $display("FAIL cancel_no_pulse: got %b expected 0", corte_terminado); else n_pass++;
    endtask

    task automatic test_priority();
        apply(K_GRAB, 12'h0); apply(K_GUA, 12'h0AA); apply(K_GRAB, 12'h0);
        apply(K_GRAB | K_INI, 12'h0);
        n_checks++; if (estado_actual !== 3'd1 || num_puntos !== 10'd0) $display("FAIL prio_grab_over_ini: got %0d/%0d expected 1/0", estado_actual, num_puntos); else n_pass++;
        apply(K_GRAB, 12'h0);
        n_checks++; if (estado_actual !== 3'd0) $display("FAIL prio_empty_stop: got %0d expected 0", estado_actual); else n_pass++;
        apply(K_INI, 12'h0);
        n_checks++; if (estado_actual !== 3'd0) $display("FAIL prio_ini_idle: got %0d expected 0", estado_actual); else n_pass++;
        apply(K_GRAB, 12'h0); apply(K_GUA, 12'h0BB); apply(K_GRAB, 12'h0);
        apply(K_INI | K_PAU, 12'h0);
        n_checks++; if (estado_actual !== 3'd3) $display("FAIL prio_ini_over_pau: got %0d expected 3", estado_actual); else n_pass++;
        apply(K_PAU | K_SIG, 12'h0);
        n_checks++; if (estado_actual !== 3'd4 || corte_terminado !== 1'b0) $display("FAIL prio_pau_over_sig: got %0d/%b expected 4/0", estado_actual, corte_terminado); else n_pass++;
        apply(K_NONE, 12'h0);
        n_checks++; if (coord_salida !== 12'h0BB) $display("FAIL prio_coord: got %h expected 0BB", coord_salida); else n_pass++;
    endtask

    task automatic test_full();
        apply_small(K_GRAB, 12'h0);
        apply_small(K_GUA, 12'h101); apply_small(K_GUA, 12'h202); apply_small(K_GUA, 12'h303);
        n_checks++; if (s_num !== 3'd3 || s_lleno !== 1'b0) $display("FAIL full_three: got %0d/%b expected 3/0", s_num, s_lleno); else n_pass++;
        apply_small(K_GUA, 12'h404);
        n_checks++; if (s_num !== 3'd4 || s_lleno !== 1'b1) $display("FAIL full_four: got %0d/%b expected 4/1", s_num, s_lleno); else n_pass++;
        apply_small(K_GUA, 12'h505);
        n_checks++; if (s_num !== 3'd4 || s_lleno !== 1'b1) $display("FAIL full_fifth: got %0d/%b expected 4/1", s_num, s_lleno); else n_pass++;
        apply_small(K_GRAB, 12'h0); apply_small(K_INI, 12'h0);
        n_checks++; if (s_estado !== 3'd3 || s_cortando !== 1'b1) $display("FAIL full_play: got %0d/%b expected 3/1", s_estado, s_cortando); else n_pass++;
        apply_small(K_NONE, 12'h0);
        n_checks++; if (s_coord !== 12'h101) $display("FAIL full_p0: got %h expected 101", s_coord); else n_pass++;
        repeat (3) begin apply_small(K_SIG, 12'h0); apply_small(K_NONE, 12'h0); end
        n_checks++; if (s_coord !== 12'h404 || s_corte !== 1'b0) $display("FAIL full_p3: got %h/%b expected 404/0", s_coord, s_corte); else n_pass++;
        apply_small(K_SIG, 12'h0);
        n_checks++; if (s_corte !== 1'b1) $display("FAIL full_end_pulse: got %b expected 1", s_corte); else n_pass++;
        apply_small(K_NONE, 12'h0);
`ifdef REPETIR_CICLO_EN
        n_checks++; if (s_coord !== 12'h101 || s_estado !== 3'd3) $display("FAIL full_wrap: got %h/%0d expected 101/3", s_coord, s_estado); else n_pass++;
`else
        n_checks++; if (s_coord !== 12'h404 || s_estado !== 3'd5) $display("FAIL full_no_fifth: got %h/%0d expected 404/5", s_coord, s_estado); else n_pass++;
`endif
    endtask

    task automatic test_reset_during_playback();
        apply(K_CAN, 12'h0); apply(K_GRAB, 12'h0);
        apply(K_GUA, 12'h5A5); apply(K_GUA, 12'hA5A); apply(K_GRAB, 12'h0);
        apply(K_INI, 12'h0); apply(K_NONE, 12'h0);
        n_checks++; if (coord_salida !== 12'h5A5) $display("FAIL rst_play_pre: got %h expected 5A5", coord_salida); else n_pass++;
        grabar = 1'b1;
        do_reset(2);
        grabar = 1'b0;
        n_checks++; if (estado_actual !== 3'd0 || num_puntos !== 10'd0) $display("FAIL rst_play_state: got %0d/%0d expected 0/0", estado_actual, num_puntos); else n_pass++;
        n_checks++; if ({cortando, lleno, corte_terminado} !== 3'b000 || coord_salida !== 12'h000) $display("FAIL rst_play_outs: got %b/%h expected 000/000", {cortando, lleno, corte_terminado}, coord_salida); else n_pass++;
    endtask

    task automatic test_random();
        logic [5:0] k;
        int r;
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 2)       k = K_CAN;
            else if (r < 7)  k = K_GRAB;
            else if (r < 12) k = K_INI;
            else if (r < 17) k = K_PAU;
            else if (r < 55) k = K_SIG;
            else if (r < 95) k = K_GUA;
            else             k = K_NONE;
            if ($urandom_range(0, 9) == 0) k = k | 6'(1 << $urandom_range(0, 5));
            apply(k, 12'($urandom));
            n_checks++; if (estado_actual !== 3'(m_state)) $display("FAIL rand_state @%0d: got %0d expected %0d", i, estado_actual, m_state); else n_pass++;
            n_checks++; if (num_puntos !== 10'(pts.size())) $display("FAIL rand_num @%0d: got %0d expected %0d", i, num_puntos, pts.size()); else n_pass++;
            n_checks++; if (cortando !== (m_state == S_CORTAR)) $display("FAIL rand_cortando @%0d: got %b expected %b", i, cortando, m_state == S_CORTAR); else n_pass++;
            n_checks++; if (lleno !== (pts.size() == 512)) $display("FAIL rand_lleno @%0d: got %b expected %b", i, lleno, pts.size() == 512); else n_pass++;
            n_checks++; if (corte_terminado !== m_fin) $display("FAIL rand_pulse @%0d: got %b expected %b", i, corte_terminado, m_fin); else n_pass++;
            n_checks++; if (coord_salida !== m_coord) $display("FAIL rand_coord @%0d: got %h expected %h", i, coord_salida, m_coord); else n_pass++;
        end
    endtask

    initial begin
        reset = 1'b0;
        {cancelar, grabar, iniciar_detener, pausar_reanudar, dato_siguiente, guardar_xy} = 6'b0;
        {s_cancelar, s_grabar, s_iniciar, s_pausar, s_siguiente, s_guardar} = 6'b0;
        coord_sensor = 12'h000;
        s_sensor     = 12'h000;
        model_reset();
        @(negedge clock);
        test_reset();
        test_path();
        test_pause();
        test_cancel();
        test_priority();
        test_full();
        test_reset_during_playback();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
